// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter onto a single-ported synchronous RAM, one access per 3 cycles.
// Optional round-robin arbitration is enabled by defining MEM_ARBITER_RR_EN; default is fixed data priority.
module mem_arbiter (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_req,
    input  logic [13:0] i_addr,
    output logic        i_gnt,
    output logic        i_rvalid,
    output logic [31:0] i_rdata,
    input  logic        d_req,
    input  logic [13:0] d_addr,
    input  logic [1:0]  d_size,
    input  logic [31:0] d_wdata,
    output logic        d_gnt,
    output logic        d_rvalid,
    output logic [31:0] d_rdata,
    output logic        d_err,
    output logic        m_en,
    output logic [11:0] m_addr,
    output logic [31:0] m_wdata,
    output logic [3:0]  m_wstrb,
    input  logic [31:0] m_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    state_t      state_q;
    logic        i_gnt_q, d_gnt_q, i_rvalid_q, d_rvalid_q, d_err_q;
    logic [31:0] i_rdata_q, d_rdata_q;
    logic        m_en_q;
    logic [11:0] m_addr_q;
    logic [31:0] m_wdata_q;
    logic [3:0]  m_wstrb_q;
    logic        src_d_q, load_q, misal_q;
    logic [1:0]  off_q;
`ifdef MEM_ARBITER_RR_EN
    logic        last_d_q;
`endif

    logic        pick_d_d, misal_d;
    logic [3:0]  wstrb_d;
    logic [31:0] wdata_d;
    logic        unused_addr;

    // Fetches are word accesses; the byte offset of i_addr carries no information.
    assign unused_addr = ^i_addr[1:0];

    always_comb begin
        misal_d = 1'b0;
        wstrb_d = 4'b0000;
        wdata_d = d_wdata << {d_addr[1:0], 3'b000};
`ifdef MEM_ARBITER_RR_EN
        pick_d_d = d_req & (~i_req | ~last_d_q);
`else
        pick_d_d = d_req;
`endif
        case (d_size)
            2'b01: wstrb_d = 4'b0001 << d_addr[1:0];
            2'b10: begin
                if (d_addr[0]) misal_d = 1'b1;
                else           wstrb_d = 4'b0011 << d_addr[1:0];
            end
            2'b11: begin
                if (d_addr[1:0] != 2'b00) misal_d = 1'b1;
                else                      wstrb_d = 4'b1111;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q    <= IDLE;
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            i_rdata_q  <= 32'h0;
            d_rdata_q  <= 32'h0;
            m_en_q     <= 1'b0;
            m_addr_q   <= 12'h0;
            m_wdata_q  <= 32'h0;
            m_wstrb_q  <= 4'h0;
            src_d_q    <= 1'b0;
            load_q     <= 1'b0;
            misal_q    <= 1'b0;
            off_q      <= 2'b00;
`ifdef MEM_ARBITER_RR_EN
            last_d_q   <= 1'b0;
`endif
        end else begin
            i_gnt_q    <= 1'b0;
            d_gnt_q    <= 1'b0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            d_err_q    <= 1'b0;
            m_en_q     <= 1'b0;
            m_wstrb_q  <= 4'h0;
            case (state_q)
                IDLE: begin
                    if (i_req || d_req) begin
                        state_q <= ACCESS;
                        m_en_q  <= 1'b1;
                        src_d_q <= pick_d_d;
`ifdef MEM_ARBITER_RR_EN
                        last_d_q <= pick_d_d;
`endif
                        if (pick_d_d) begin
                            d_gnt_q   <= 1'b1;
                            m_addr_q  <= d_addr[13:2];
                            m_wstrb_q <= wstrb_d;
                            m_wdata_q <= wdata_d;
                            load_q    <= (d_size == 2'b00);
                            misal_q   <= misal_d;
                            off_q     <= d_addr[1:0];
                        end else begin
                            i_gnt_q  <= 1'b1;
                            m_addr_q <= i_addr[13:2];
                        end
                    end
                end
                ACCESS: state_q <= RESP;
                RESP: begin
                    // RAM data for the access sampled at the ACCESS->RESP edge is valid now.
                    state_q <= IDLE;
                    if (src_d_q) begin
                        d_rvalid_q <= 1'b1;
                        d_err_q    <= misal_q;
                        if (load_q) d_rdata_q <= m_rdata >> {off_q, 3'b000};
                    end else begin
                        i_rvalid_q <= 1'b1;
                        i_rdata_q  <= m_rdata;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign i_gnt    = i_gnt_q;
    assign d_gnt    = d_gnt_q;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign d_err    = d_err_q;
    assign i_rdata  = i_rdata_q;
    assign d_rdata  = d_rdata_q;
    assign m_en     = m_en_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_wstrb  = m_wstrb_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: RAM model, transaction-level reference model, directed and random traffic.
// Honours MEM_ARBITER_RR_EN the same way as the design.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        i_req = 1'b0, d_req = 1'b0;
    logic [13:0] i_addr = 14'h0, d_addr = 14'h0;
    logic [1:0]  d_size = 2'b00;
    logic [31:0] d_wdata = 32'h0, m_rdata = 32'h0;
    logic        i_gnt, i_rvalid, d_gnt, d_rvalid, d_err, m_en;
    logic [31:0] i_rdata, d_rdata, m_wdata;
    logic [11:0] m_addr;
    logic [3:0]  m_wstrb;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .resetn(resetn),
        .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
        .d_req(d_req), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
        .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata), .d_err(d_err),
        .m_en(m_en), .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_rdata(m_rdata)
    );

    int n_chk = 0, n_fail = 0;
    bit cmp_on = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- RAM and reference model ----------------
    logic [31:0] ram   [0:4095];
    logic [7:0]  ref_b [0:16383];
    int          ph;
    bit          w_d;
`ifdef MEM_ARBITER_RR_EN
    bit          last_d;
`endif
    logic [13:0] w_addr;
    logic [1:0]  w_size;
    logic [31:0] w_wdata, w_word;
    bit          e_ignt, e_dgnt, e_irv, e_drv, e_men, e_err, d_known;
    logic [11:0] e_maddr;
    logic [3:0]  e_wstrb;
    logic [31:0] e_wdata, e_irdata, e_drdata;

    function automatic bit is_misal(input logic [1:0] sz, input logic [13:0] a);
        return (sz == 2'b10 && a[0]) || (sz == 2'b11 && a[1:0] != 2'b00);
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b01) ? 1 : (sz == 2'b10) ? 2 : 4;
    endfunction

    task automatic model_reset();
        ph = 0;
        e_ignt = 0; e_dgnt = 0; e_irv = 0; e_drv = 0; e_men = 0; e_err = 0;
        e_wstrb = 4'h0; e_maddr = 12'h0; e_wdata = 32'h0;
        e_irdata = 32'h0; e_drdata = 32'h0; d_known = 1;
`ifdef MEM_ARBITER_RR_EN
        last_d = 0;
`endif
    endtask

    task automatic model_step();
        bit wd;
        int base;
        e_ignt = 0; e_dgnt = 0; e_irv = 0; e_drv = 0; e_men = 0; e_wstrb = 4'h0;
        case (ph)
            0: if (i_req || d_req) begin
`ifdef MEM_ARBITER_RR_EN
                wd = (i_req && d_req) ? !last_d : d_req;
                last_d = wd;
`else
                wd = d_req;
`endif
                w_d     = wd;
                w_addr  = wd ? d_addr : i_addr;
                w_size  = wd ? d_size : 2'b00;
                w_wdata = d_wdata;
                e_ignt  = !wd;
                e_dgnt  = wd;
                e_men   = 1;
                e_maddr = w_addr[13:2];
                if (wd && w_size != 2'b00 && !is_misal(w_size, w_addr)) begin
                    for (int k = 0; k < nbytes(w_size); k++)
                        e_wstrb[(int'(w_addr[1:0]) + k) % 4] = 1'b1;
                    e_wdata = w_wdata << (8 * w_addr[1:0]);
                end
                ph = 1;
            end
            1: begin
                base   = int'(w_addr) & ~3;
                w_word = {ref_b[base+3], ref_b[base+2], ref_b[base+1], ref_b[base]};
                if (w_d && w_size != 2'b00 && !is_misal(w_size, w_addr))
                    for (int k = 0; k < nbytes(w_size); k++)
                        ref_b[int'(w_addr) + k] = w_wdata[8*k +: 8];
                ph = 2;
            end
            default: begin
                if (w_d) begin
                    e_drv = 1;
                    e_err = is_misal(w_size, w_addr);
                    if (w_size == 2'b00) begin
                        e_drdata = w_word >> (8 * w_addr[1:0]);
                        d_known  = 1;
                    end else begin
                        d_known = 0;
                    end
                end else begin
                    e_irv    = 1;
                    e_irdata = w_word;
                end
                ph = 0;
            end
        endcase
    endtask

    initial begin
        for (int w = 0; w < 4096; w++) ram[w] = 32'h0;
        for (int b = 0; b < 16384; b++) ref_b[b] = 8'h0;
        for (int w = 0; w < 16; w++) ram[w] = $urandom;
        ram[0] = 32'h11223344;
        ram[1] = 32'h00000013;
        ram[2] = 32'h11223344;
        for (int w = 0; w < 16; w++)
            for (int k = 0; k < 4; k++) ref_b[4*w+k] = ram[w][8*k +: 8];
        model_reset();
        forever begin
            @(posedge clk or negedge resetn);
            if (!resetn) model_reset();
            else begin
                if (m_en) begin
                    m_rdata <= ram[m_addr];
                    for (int k = 0; k < 4; k++)
                        if (m_wstrb[k]) ram[m_addr][8*k +: 8] = m_wdata[8*k +: 8];
                end
                model_step();
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial forever begin
        @(negedge clk);
        if (cmp_on) begin
            chk("i_gnt", i_gnt, e_ignt);
            chk("d_gnt", d_gnt, e_dgnt);
            chk("i_rvalid", i_rvalid, e_irv);
            chk("d_rvalid", d_rvalid, e_drv);
            chk("m_en", m_en, e_men);
            chk("m_wstrb", m_wstrb, e_wstrb);
            chk("i_rdata", i_rdata, e_irdata);
            if (e_drv) chk("d_err", d_err, e_err);
            if (e_men) chk("m_addr", m_addr, e_maddr);
            if (e_wstrb != 0) chk("m_wdata", m_wdata, e_wdata);
            if (d_known) chk("d_rdata", d_rdata, e_drdata);
        end
    end

    // ---------------- stimulus ----------------
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " i_gnt"}, i_gnt, 0);       chk({tag, " d_gnt"}, d_gnt, 0);
        chk({tag, " i_rvalid"}, i_rvalid, 0); chk({tag, " d_rvalid"}, d_rvalid, 0);
        chk({tag, " d_err"}, d_err, 0);       chk({tag, " m_en"}, m_en, 0);
        chk({tag, " m_wstrb"}, m_wstrb, 0);   chk({tag, " m_addr"}, m_addr, 0);
        chk({tag, " m_wdata"}, m_wdata, 0);   chk({tag, " i_rdata"}, i_rdata, 0);
        chk({tag, " d_rdata"}, d_rdata, 0);
    endtask

    task automatic do_reset();
        tick(); #2 resetn = 1'b0;
        tick(); #2 resetn = 1'b1;
    endtask

    int n_rv, n_gr;
    logic [3:0] gseq;

    initial begin
        repeat (2) tick();
        chk_zero("reset");
        #2 resetn = 1'b1;

        // Lone fetch of word 1
        tick(); i_req = 1; i_addr = 14'h0004;
        tick(); chk("fetch gnt", i_gnt, 1); chk("fetch m_en", m_en, 1);
        chk("fetch m_addr", m_addr, 12'd1); chk("fetch no d_gnt", d_gnt, 0); i_req = 0;
        tick(); chk("fetch m_en off", m_en, 0);
        tick(); chk("fetch rvalid", i_rvalid, 1); chk("fetch rdata", i_rdata, 32'h13);

        // Store byte to 0x13 lands in lane 3 of word 4
        d_req = 1; d_addr = 14'h0013; d_size = 2'b01; d_wdata = 32'h000000AB;
        tick(); chk("sb gnt", d_gnt, 1); chk("sb m_addr", m_addr, 12'd4);
        chk("sb wstrb", m_wstrb, 4'b1000); chk("sb wdata", m_wdata, 32'hAB000000); d_req = 0;
        tick();
        tick(); chk("sb rvalid", d_rvalid, 1); chk("sb err", d_err, 0);

        // Misaligned store word writes nothing and flags an error
        d_req = 1; d_addr = 14'h0006; d_size = 2'b11; d_wdata = 32'hDEADBEEF;
        tick(); chk("sw-mis gnt", d_gnt, 1); chk("sw-mis wstrb", m_wstrb, 4'b0000); d_req = 0;
        tick();
        tick(); chk("sw-mis rvalid", d_rvalid, 1); chk("sw-mis err", d_err, 1);
        chk("sw-mis ram", ram[1], 32'h00000013);

        // Offset load
        d_req = 1; d_addr = 14'h0002; d_size = 2'b00;
        tick(); chk("lw gnt", d_gnt, 1); d_req = 0;
        tick();
        tick(); chk("lw rvalid", d_rvalid, 1); chk("lw rdata", d_rdata, 32'h00001122);

        // Reset in ACCESS of a following load drops it
        d_req = 1; d_addr = 14'h000A; d_size = 2'b00;
        tick(); chk("lw2 gnt", d_gnt, 1); d_req = 0;
        #2 resetn = 1'b0;
        #1 chk_zero("midrst");
        tick(); #2 resetn = 1'b1;
        n_rv = 0;
        repeat (4) begin tick(); if (d_rvalid) n_rv++; end
        chk("midrst no rvalid", n_rv, 0);
        d_req = 1; d_addr = 14'h0002; d_size = 2'b00;
        tick(); chk("lw3 gnt", d_gnt, 1); d_req = 0;
        tick();
        tick(); chk("lw3 rvalid", d_rvalid, 1); chk("lw3 rdata", d_rdata, 32'h00001122);

        // Both requesters held for 12 cycles from reset
        do_reset();
        tick(); i_req = 1; i_addr = 14'h0008; d_req = 1; d_addr = 14'h0000; d_size = 2'b00;
        n_gr = 0; gseq = 4'h0;
        repeat (12) begin
            tick();
            if (i_gnt || d_gnt) begin n_gr++; gseq = {gseq[2:0], d_gnt}; end
        end
        i_req = 0; d_req = 0;
        chk("contend grants", n_gr, 4);
`ifdef MEM_ARBITER_RR_EN
        chk("contend order", gseq, 4'b1010);
`else
        chk("contend order", gseq, 4'b1111);
`endif

        // Randomized traffic
        for (int c = 0; c < 2000; c++) begin
            tick();
            if (i_req && i_gnt) i_req = 0;
            else if (!i_req && $urandom_range(2) == 0) begin
                i_req = 1; i_addr = 14'($urandom_range(63));
            end
            if (d_req && d_gnt) d_req = 0;
            else if (!d_req && $urandom_range(2) == 0) begin
                d_req = 1; d_addr = 14'($urandom_range(63));
                d_size = 2'($urandom_range(3)); d_wdata = $urandom;
            end
        end
        tick(); i_req = 0; d_req = 0;
        repeat (4) tick();
        for (int w = 0; w < 16; w++)
            chk($sformatf("ram w%0d", w), ram[w],
                {ref_b[4*w+3], ref_b[4*w+2], ref_b[4*w+1], ref_b[4*w]});

        cmp_on = 0;
        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 resetn  input  1  asynchronous active-low reset.
REQ-003 i_req  input  1  fetch request; held with i_addr stable until i_gnt.
REQ-004 i_addr  input  14  fetch byte address; bits [1:0] ignored (word fetch).
REQ-005 i_gnt  output  1  one-cycle pulse: fetch request accepted.
REQ-006 i_rvalid  output  1  one-cycle pulse: i_rdata valid.
REQ-007 i_rdata  output  32  fetched word.
REQ-008 d_req  input  1  data request; held with d_addr/d_size/d_wdata stable until d_gnt.
REQ-009 d_addr  input  14  data byte address.
REQ-010 d_size  input  2  00 load word; 01 store byte; 10 store half; 11 store word.
REQ-011 d_wdata  input  32  store data, right-aligned.
REQ-012 d_gnt  output  1  one-cycle pulse: data request accepted.
REQ-013 d_rvalid  output  1  one-cycle pulse: data access complete, loads and stores.
REQ-014 d_rdata  output  32  load word shifted right by 8*d_addr[1:0], zero-filled.
REQ-015 d_err  output  1  asserted with d_rvalid on a misaligned store.
REQ-016 m_en  output  1  RAM access strobe; RAM samples it on the next edge.
REQ-017 m_addr  output  12  RAM word address (byte address [13:2]).
REQ-018 m_wdata  output  32  store data shifted into byte lanes.
REQ-019 m_wstrb  output  4  byte write enables; 0000 means read.
REQ-020 m_rdata  input  32  RAM read word, valid one edge after m_en is sampled.

Function
REQ-021 The FSM SHALL have three states: IDLE, ACCESS, RESP.
REQ-022 IDLE with any request at edge E0 -> ACCESS; pulse winner's gnt; drive m_en=1, m_addr, m_wstrb, m_wdata.
REQ-023 ACCESS at E1 -> RESP; m_en, gnt and m_wstrb SHALL return to 0.
REQ-024 RESP at E2 -> IDLE; winner's rvalid pulses; rdata registered from m_rdata.
REQ-025 Latency: request sampled at E0, rvalid high after E2; at most one access per 3 cycles; next grant no earlier than E3.
REQ-026 Requests arriving or dropped during ACCESS/RESP SHALL be ignored until IDLE.
REQ-027 Lane rules: byte wstrb=0001<<addr[1:0]; half wstrb=0011<<addr[1:0]; word wstrb=1111; m_wdata=d_wdata<<8*addr[1:0].
REQ-028 Misaligned store (half with addr[0]=1, word with addr[1:0]!=0) SHALL write nothing (wstrb=0000), still complete, and set d_err with d_rvalid.
REQ-029 Store completions SHALL pulse d_rvalid; d_rdata content is then don't-care.
REQ-030 Outputs i_rdata and d_rdata SHALL hold their last value between rvalid pulses.
REQ-031 Only one of i_gnt/d_gnt and one of i_rvalid/d_rvalid SHALL ever be high in a cycle.

Reset
REQ-032 resetn low SHALL immediately force IDLE and clear all outputs to 0 (gnt, rvalid, err, m_en, m_wstrb, m_addr, m_wdata, rdata) and the last-grant flag to "fetch".
REQ-033 Reset mid-access SHALL drop the in-flight transaction with no rvalid; a write already sampled by the RAM is not undone.

Configuration
REQ-034 Macro MEM_ARBITER_RR_EN defined: on simultaneous i_req and d_req, grant the requester not granted last (round-robin); a lone requester always wins.
REQ-035 Macro undefined: on simultaneous requests d_req SHALL always win (fixed data priority); no last-grant flag is implemented.

Verification
REQ-036 Lone fetch i_addr=0x0004, RAM word1=0x00000013 -> i_gnt at E0, m_en/m_addr=1 for one cycle, i_rvalid with i_rdata=0x00000013 after E2.
REQ-037 Store byte d_addr=0x0013, d_wdata=0xAB -> m_addr=4, m_wstrb=1000, m_wdata=0xAB000000; d_rvalid=1, d_err=0.
REQ-038 Store word d_addr=0x0006 -> m_wstrb=0000, d_rvalid=1 with d_err=1, RAM unchanged.
REQ-039 i_req and d_req held high for 12 cycles -> fixed: four d_gnt, zero i_gnt; with MEM_ARBITER_RR_EN: grants alternate d,i,d,i.
REQ-040 Load d_addr=0x0002 of word 0x11223344 -> d_rdata=0x00001122; resetn pulsed low in ACCESS of a following load -> all outputs 0, no d_rvalid, next request served normally.
